// File: rtl/conv3x3_engine.sv
`default_nettype none
// ============================================================================
//  Module   : conv3x3_engine
//  Brief    : Three-stage 3x3 convolution with run-time kernel select
//             (box / gauss / sharpen / user), saturation and backpressure.
//  Revision : 1.0  initial release
// ============================================================================
module conv3x3_engine #(
    parameter int PIXEL_W = 8,
    parameter int COEF_W  = 8,
    parameter int SHIFT_W = 4,
    parameter int ACC_W   = PIXEL_W + COEF_W + 5
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    input  logic [1:0]           i_mode,
    input  logic [9*PIXEL_W-1:0] i_pixel_data,
    input  logic                 i_pixel_data_valid,
    output logic                 o_pixel_ready,
    input  logic                 i_coef_wr,
    input  logic [3:0]           i_coef_addr,
    input  logic [COEF_W-1:0]    i_coef_data,
    output logic [PIXEL_W-1:0]   o_convolved_data,
    output logic                 o_convolved_data_valid,
    input  logic                 i_out_ready,
    output logic                 o_clip
);

    // Product of a zero-extended pixel and a signed coefficient.
    localparam int PROD_W = PIXEL_W + COEF_W + 1;

    localparam logic [1:0] c_MODE_BOX   = 2'd0;
    localparam logic [1:0] c_MODE_GAUSS = 2'd1;
    localparam logic [1:0] c_MODE_SHARP = 2'd2;
    localparam logic [1:0] c_MODE_USER  = 2'd3;

    localparam logic signed [COEF_W-1:0] c_ZERO = '0;
    localparam logic signed [COEF_W-1:0] c_ONE  = COEF_W'(1);
    localparam logic signed [COEF_W-1:0] c_TWO  = COEF_W'(2);
    localparam logic signed [COEF_W-1:0] c_FOUR = COEF_W'(4);
    localparam logic signed [COEF_W-1:0] c_FIVE = COEF_W'(5);
    localparam logic signed [COEF_W-1:0] c_NEG1 = '1;

    localparam logic signed [ACC_W-1:0] c_NINE    = ACC_W'(9);
    localparam logic signed [ACC_W-1:0] c_PIX_MAX = ACC_W'({PIXEL_W{1'b1}});

    // User coefficient bank
    logic signed [COEF_W-1:0]  r_coef [0:8];
    logic [SHIFT_W-1:0]        r_shift;

    // Handshake
    logic                      w_stall;
    logic                      w_en;
    logic                      w_accept;

    // Stage 1
    logic signed [COEF_W-1:0]  w_coef  [0:8];
    logic signed [PROD_W-1:0]  w_prod  [0:8];
    logic signed [PROD_W-1:0]  r_prod1 [0:8];
    logic                      r_v1;
    logic [1:0]                r_mode1;
    logic [SHIFT_W-1:0]        r_shift1;

    // Stage 2
    logic signed [ACC_W-1:0]   w_sum;
    logic signed [ACC_W-1:0]   r_sum2;
    logic                      r_v2;
    logic [1:0]                r_mode2;
    logic [SHIFT_W-1:0]        r_shift2;

    // Stage 3
    logic signed [ACC_W-1:0]   w_res;
    logic [PIXEL_W-1:0]        w_sat;
    logic                      w_clip;
    logic [PIXEL_W-1:0]        r_out;
    logic                      r_out_valid;
    logic                      r_clip;

    // The whole pipeline freezes while a valid output waits for the consumer.
    always_comb begin
        w_stall  = r_out_valid & ~i_out_ready;
        w_en     = ~w_stall;
        w_accept = i_pixel_data_valid & w_en;
    end

    assign o_pixel_ready          = w_en;
    assign o_convolved_data       = r_out;
    assign o_convolved_data_valid = r_out_valid;
    assign o_clip                 = r_clip;

    // User bank: identity on reset; addresses above 9 are silently dropped.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            for (int k = 0; k < 9; k++) begin
                r_coef[k] <= (k == 4) ? c_ONE : c_ZERO;
            end
            r_shift <= '0;
        end else if (i_coef_wr) begin
            for (int k = 0; k < 9; k++) begin
                if (i_coef_addr == 4'(k)) begin
                    r_coef[k] <= i_coef_data;
                end
            end
            if (i_coef_addr == 4'd9) begin
                r_shift <= i_coef_data[SHIFT_W-1:0];
            end
        end
    end

    // Pick the coefficient set for the incoming beat and form the tap products.
    always_comb begin
        for (int k = 0; k < 9; k++) begin
            w_coef[k] = c_ONE;
            case (i_mode)
                c_MODE_BOX:   w_coef[k] = c_ONE;
                c_MODE_GAUSS: w_coef[k] = (k == 4) ? c_FOUR : ((k % 2) == 1) ? c_TWO : c_ONE;
                c_MODE_SHARP: w_coef[k] = (k == 4) ? c_FIVE : ((k % 2) == 1) ? c_NEG1 : c_ZERO;
                c_MODE_USER:  w_coef[k] = r_coef[k];
                default:      w_coef[k] = c_ONE;
            endcase
            w_prod[k] = PROD_W'($signed({1'b0, i_pixel_data[k*PIXEL_W +: PIXEL_W]}))
                      * PROD_W'(w_coef[k]);
        end
    end

    // Signed nine-term accumulation of the stage-1 products.
    always_comb begin
        w_sum = '0;
        for (int k = 0; k < 9; k++) begin
            w_sum = w_sum + ACC_W'(r_prod1[k]);
        end
    end

    // Kernel-specific normalisation followed by clamp to the pixel range.
    always_comb begin
        w_res = r_sum2;
        case (r_mode2)
            c_MODE_BOX:   w_res = r_sum2 / c_NINE;
            c_MODE_GAUSS: w_res = r_sum2 >>> 4;
            c_MODE_SHARP: w_res = r_sum2;
            c_MODE_USER:  w_res = r_sum2 >>> r_shift2;
            default:      w_res = r_sum2;
        endcase
        w_clip = 1'b0;
        w_sat  = w_res[PIXEL_W-1:0];
        if (w_res < 0) begin
            w_sat  = '0;
            w_clip = 1'b1;
        end else if (w_res > c_PIX_MAX) begin
            w_sat  = '1;
            w_clip = 1'b1;
        end
    end

    // Three pipeline stages; every register holds while stalled.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_v1        <= 1'b0;
            r_mode1     <= '0;
            r_shift1    <= '0;
            r_v2        <= 1'b0;
            r_mode2     <= '0;
            r_shift2    <= '0;
            r_sum2      <= '0;
            r_out_valid <= 1'b0;
            r_out       <= '0;
            r_clip      <= 1'b0;
            for (int k = 0; k < 9; k++) begin
                r_prod1[k] <= '0;
            end
        end else if (w_en) begin
            r_v1     <= w_accept;
            r_mode1  <= i_mode;
            r_shift1 <= r_shift;
            for (int k = 0; k < 9; k++) begin
                r_prod1[k] <= w_prod[k];
            end
            r_v2        <= r_v1;
            r_mode2     <= r_mode1;
            r_shift2    <= r_shift1;
            r_sum2      <= w_sum;
            r_out_valid <= r_v2;
            r_out       <= w_sat;
            r_clip      <= w_clip & r_v2;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_conv3x3_engine.sv
`default_nettype none
// ============================================================================
//  Module   : tb_conv3x3_engine
//  Brief    : Self-checking bench for conv3x3_engine (model + directed vectors)
//  Revision : 1.0  initial release
// ============================================================================
module tb_conv3x3_engine;

    localparam int PW = 8;
    localparam int CW = 8;
    localparam int SW = 4;

    logic           i_clk = 1'b0;
    logic           i_rst = 1'b1;
    logic [1:0]     i_mode = '0;
    logic [9*PW-1:0] i_pixel_data = '0;
    logic           i_pixel_data_valid = 1'b0;
    logic           o_pixel_ready;
    logic           i_coef_wr = 1'b0;
    logic [3:0]     i_coef_addr = '0;
    logic [CW-1:0]  i_coef_data = '0;
    logic [PW-1:0]  o_convolved_data;
    logic           o_convolved_data_valid;
    logic           i_out_ready = 1'b1;
    logic           o_clip;

    conv3x3_engine #(.PIXEL_W(PW), .COEF_W(CW), .SHIFT_W(SW)) dut (
        .i_clk                  (i_clk),
        .i_rst                  (i_rst),
        .i_mode                 (i_mode),
        .i_pixel_data           (i_pixel_data),
        .i_pixel_data_valid     (i_pixel_data_valid),
        .o_pixel_ready          (o_pixel_ready),
        .i_coef_wr              (i_coef_wr),
        .i_coef_addr            (i_coef_addr),
        .i_coef_data            (i_coef_data),
        .o_convolved_data       (o_convolved_data),
        .o_convolved_data_valid (o_convolved_data_valid),
        .i_out_ready            (i_out_ready),
        .o_clip                 (o_clip)
    );

    always #5 i_clk = ~i_clk;

    int errors = 0;
    int checks = 0;

    // ---------------- reference model ----------------
    typedef struct { int d; int c; } exp_t;
    exp_t sbq[$];
    int   m_coef [9];
    int   m_shift;

    function automatic exp_t model(input int mode, input logic [9*PW-1:0] w);
        int   g [9];
        int   s [9];
        int   sum;
        int   cf;
        int   r;
        exp_t e;
        g   = '{1, 2, 1, 2, 4, 2, 1, 2, 1};
        s   = '{0, -1, 0, -1, 5, -1, 0, -1, 0};
        sum = 0;
        for (int k = 0; k < 9; k++) begin
            case (mode)
                0:       cf = 1;
                1:       cf = g[k];
                2:       cf = s[k];
                default: cf = m_coef[k];
            endcase
            sum += cf * int'(w[k*PW +: PW]);
        end
        case (mode)
            0:       r = sum / 9;
            1:       r = sum >>> 4;
            2:       r = sum;
            default: r = sum >>> m_shift;
        endcase
        e.c = 1;
        if (r < 0)        e.d = 0;
        else if (r > 255) e.d = 255;
        else begin        e.d = r; e.c = 0; end
        return e;
    endfunction

    // Model bookkeeping at each active edge, using pre-edge signal values.
    always @(posedge i_clk) begin
        if (i_rst) begin
            sbq.delete();
            for (int k = 0; k < 9; k++) m_coef[k] <= (k == 4) ? 1 : 0;
            m_shift <= 0;
        end else begin
            if (o_convolved_data_valid && i_out_ready && sbq.size() > 0)
                void'(sbq.pop_front());
            if (i_pixel_data_valid && o_pixel_ready)
                sbq.push_back(model(int'(i_mode), i_pixel_data));
            if (i_coef_wr) begin
                if (i_coef_addr < 4'd9)
                    m_coef[i_coef_addr] <= int'($signed(i_coef_data));
                else if (i_coef_addr == 4'd9)
                    m_shift <= int'(i_coef_data[SW-1:0]);
            end
        end
    end

    // ---------------- compare process ----------------
    int       out_count = 0;
    int       last_d = 0;
    int       last_c = 0;
    int       seq[$];
    logic     prev_stall = 1'b0;
    logic [PW-1:0] prev_d = '0;

    always @(negedge i_clk) begin
        if (i_rst) begin
            prev_stall = 1'b0;
        end else begin
            checks++;
            if (o_pixel_ready !== !(o_convolved_data_valid && !i_out_ready)) begin
                errors++;
                $display("FAIL ready_rule: got %b valid=%b out_ready=%b", o_pixel_ready,
                         o_convolved_data_valid, i_out_ready);
            end
            if (prev_stall) begin
                checks++;
                if (o_convolved_data !== prev_d || o_convolved_data_valid !== 1'b1) begin
                    errors++;
                    $display("FAIL stall_hold: got %0d/v%b want %0d/v1", o_convolved_data,
                             o_convolved_data_valid, prev_d);
                end
            end
            if (o_convolved_data_valid && i_out_ready) begin
                checks++;
                if (sbq.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_out: got %0d with no beat outstanding", o_convolved_data);
                end else if (int'(o_convolved_data) != sbq[0].d || int'(o_clip) != sbq[0].c) begin
                    errors++;
                    $display("FAIL model_out: got %0d clip %0d want %0d clip %0d",
                             o_convolved_data, o_clip, sbq[0].d, sbq[0].c);
                end
                last_d = int'(o_convolved_data);
                last_c = int'(o_clip);
                seq.push_back(int'(o_convolved_data));
                out_count++;
            end
            prev_stall = o_convolved_data_valid && !i_out_ready;
            prev_d     = o_convolved_data;
        end
    end

    // ---------------- stimulus helpers ----------------
    function automatic logic [9*PW-1:0] mk(input int c, input int e, input int r);
        logic [9*PW-1:0] w;
        for (int k = 0; k < 9; k++)
            w[k*PW +: PW] = PW'((k == 4) ? c : ((k % 2) == 1) ? e : r);
        return w;
    endfunction

    function automatic logic [9*PW-1:0] one_tap(input int k, input int v);
        logic [9*PW-1:0] w;
        w = '0;
        w[k*PW +: PW] = PW'(v);
        return w;
    endfunction

    function automatic logic [9*PW-1:0] taps_k();
        logic [9*PW-1:0] w;
        for (int k = 0; k < 9; k++) w[k*PW +: PW] = PW'(k);
        return w;
    endfunction

    // Entered and left at posedge+1; leaves valid low so back-to-back calls stream.
    task automatic beat(input logic [1:0] m, input logic [9*PW-1:0] w);
        logic acc;
        int   tries;
        acc   = 1'b0;
        tries = 0;
        i_pixel_data_valid = 1'b1;
        i_mode             = m;
        i_pixel_data       = w;
        while (!acc && tries < 50) begin
            @(negedge i_clk);
            acc = o_pixel_ready;
            @(posedge i_clk);
            #1;
            tries++;
        end
        if (!acc) begin
            errors++;
            $display("FAIL accept_timeout: beat never accepted within %0d cycles", tries);
        end
        i_pixel_data_valid = 1'b0;
    endtask

    task automatic wait_out(input int snap, input string name);
        int n;
        n = 0;
        while (out_count == snap && n < 30) begin
            @(posedge i_clk);
            #1;
            n++;
        end
        if (out_count == snap) begin
            errors++;
            $display("FAIL %s_timeout: no output within %0d cycles", name, n);
        end
    endtask

    task automatic beat_check(input logic [1:0] m, input logic [9*PW-1:0] w,
                              input int ed, input int ec, input string name);
        int snap;
        snap = out_count;
        beat(m, w);
        wait_out(snap, name);
        checks++;
        if (last_d != ed || last_c != ec) begin
            errors++;
            $display("FAIL %s: got %0d clip %0d want %0d clip %0d", name, last_d, last_c, ed, ec);
        end
    endtask

    task automatic wr(input int a, input int d);
        i_coef_wr   = 1'b1;
        i_coef_addr = 4'(a);
        i_coef_data = CW'(d);
        @(posedge i_clk);
        #1;
        i_coef_wr = 1'b0;
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        int base;
        int n;

        // Reset state
        repeat (3) @(posedge i_clk);
        @(negedge i_clk);
        checks++;
        if (o_convolved_data_valid !== 1'b0 || o_convolved_data !== '0 || o_clip !== 1'b0) begin
            errors++;
            $display("FAIL reset_state: got v%b d%0d c%b want v0 d0 c0",
                     o_convolved_data_valid, o_convolved_data, o_clip);
        end
        @(posedge i_clk);
        #1;
        i_rst = 1'b0;

        // Box, taps 0..8: output valid on the third edge after acceptance
        beat(2'd0, taps_k());
        for (int e = 0; e < 3; e++) begin
            @(negedge i_clk);
            checks++;
            if (e < 2 && o_convolved_data_valid !== 1'b0) begin
                errors++;
                $display("FAIL latency_early: got valid=1 after edge %0d want 0", e + 1);
            end else if (e == 2 && (o_convolved_data_valid !== 1'b1 || o_convolved_data !== 8'd4
                                    || o_clip !== 1'b0)) begin
                errors++;
                $display("FAIL box_taps: got v%b d%0d c%b want v1 d4 c0",
                         o_convolved_data_valid, o_convolved_data, o_clip);
            end
            @(posedge i_clk);
            #1;
        end
        beat_check(2'd0, mk(255, 255, 255), 255, 0, "box_255");

        beat_check(2'd1, mk(255, 255, 255), 255, 0, "gauss_255");
        beat_check(2'd1, mk(16, 0, 0),      4,   0, "gauss_centre");

        beat_check(2'd2, mk(200, 10, 10),   255, 1, "sharpen_hi");
        beat_check(2'd2, mk(10, 200, 200),  0,   1, "sharpen_lo");

        // User bank
        wr(4, 3);
        wr(9, 1);
        beat_check(2'd3, mk(101, 0, 0), 151, 0, "user_c3_s1");
        wr(0, -3);
        wr(4, 0);
        beat_check(2'd3, one_tap(0, 1), 0, 1, "user_neg");

        // Write in the same cycle as a beat: that beat uses the old bank
        base = seq.size();
        i_coef_wr   = 1'b1;
        i_coef_addr = 4'd4;
        i_coef_data = 8'd2;
        beat(2'd3, mk(50, 0, 0));
        i_coef_wr = 1'b0;
        beat(2'd3, mk(50, 0, 0));
        n = 0;
        while (seq.size() < base + 2 && n < 30) begin
            @(posedge i_clk);
            #1;
            n++;
        end
        checks++;
        if (seq.size() < base + 2) begin
            errors++;
            $display("FAIL wr_same_cycle: got %0d outputs want 2", seq.size() - base);
        end else if (seq[base] != 0 || seq[base+1] != 50) begin
            errors++;
            $display("FAIL wr_same_cycle: got %0d,%0d want 0,50", seq[base], seq[base+1]);
        end

        // Ignored address
        wr(12, 5);
        beat_check(2'd3, mk(100, 0, 0), 100, 0, "addr12_ignored");

        // Backpressure: six streaming beats, consumer stalls 4 cycles after first output
        base = seq.size();
        fork
            begin
                for (int i = 1; i <= 6; i++) beat(2'd0, mk(9 * i, 9 * i, 9 * i));
            end
            begin
                int t;
                t = 0;
                do begin
                    @(negedge i_clk);
                    t++;
                end while (!o_convolved_data_valid && t < 40);
                @(posedge i_clk);
                #1;
                i_out_ready = 1'b0;
                @(negedge i_clk);
                checks++;
                if (o_pixel_ready !== 1'b0) begin
                    errors++;
                    $display("FAIL stall_ready: got %b want 0", o_pixel_ready);
                end
                @(posedge i_clk);
                repeat (3) @(posedge i_clk);
                #1;
                i_out_ready = 1'b1;
            end
        join
        n = 0;
        while (seq.size() < base + 6 && n < 40) begin
            @(posedge i_clk);
            #1;
            n++;
        end
        checks++;
        if (seq.size() != base + 6) begin
            errors++;
            $display("FAIL bp_count: got %0d outputs want 6", seq.size() - base);
        end else begin
            for (int i = 0; i < 6; i++) begin
                if (seq[base+i] != 9 * (i + 1)) begin
                    errors++;
                    $display("FAIL bp_order: item %0d got %0d want %0d", i, seq[base+i], 9 * (i + 1));
                    break;
                end
            end
        end

        // Reset with two beats in flight
        beat(2'd0, mk(30, 30, 30));
        beat(2'd0, mk(40, 40, 40));
        i_rst = 1'b1;
        @(posedge i_clk);
        #1;
        i_rst = 1'b0;
        base = out_count;
        for (int i = 0; i < 6; i++) begin
            @(negedge i_clk);
            checks++;
            if (o_convolved_data_valid !== 1'b0 || (i == 0 && (o_convolved_data !== '0 || o_clip !== 1'b0))) begin
                errors++;
                $display("FAIL reset_flush: cycle %0d got v%b d%0d c%b want v0 d0 c0",
                         i, o_convolved_data_valid, o_convolved_data, o_clip);
            end
        end
        @(posedge i_clk);
        #1;
        beat_check(2'd3, mk(77, 0, 0), 77, 0, "identity_bank");

        repeat (5) @(posedge i_clk);
        checks++;
        if (sbq.size() != 0) begin
            errors++;
            $display("FAIL drain: got %0d beats outstanding want 0", sbq.size());
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/conv3x3_engine.md
Name: conv3x3_engine

Overview:
Parametrised 3x3 convolution engine, the successor to the fixed box-blur stage in the image-processing pipeline. It accepts one 3x3 pixel window per beat from the line-buffer/window generator and produces one filtered pixel per beat. The kernel is selectable at run time: box, Gaussian, sharpen, or a user-loaded signed kernel with programmable shift. The output is clamped to the pixel range and can be stalled by backpressure from the downstream consumer (DMA/stream packer).

Parameters:
PIXEL_W, 8, unsigned pixel width in bits
COEF_W, 8, signed user-coefficient width in bits
SHIFT_W, 4, width of the user normalisation shift (0..2^SHIFT_W-1)
ACC_W, PIXEL_W+COEF_W+5, signed accumulator width (derived; do not override)

Ports:
i_clk  in  1  clock, all logic rising-edge
i_rst  in  1  synchronous active-high reset
i_mode  in  2  kernel select, sampled per accepted beat: 0 box, 1 gauss, 2 sharpen, 3 user
i_pixel_data  in  9*PIXEL_W  window; tap k at [k*PIXEL_W +: PIXEL_W], row-major, k=0 top-left, k=4 centre
i_pixel_data_valid  in  1  window valid
o_pixel_ready  out  1  engine can accept a window this cycle
i_coef_wr  in  1  user-bank write strobe
i_coef_addr  in  4  0..8 select coefficient k; 9 selects the shift register; 10..15 ignored
i_coef_data  in  COEF_W  signed coefficient, or shift value in the low SHIFT_W bits
o_convolved_data  out  PIXEL_W  filtered pixel
o_convolved_data_valid  out  1  output valid
i_out_ready  in  1  downstream accepts output
o_clip  out  1  current output was saturated (qualified by valid)

Behaviour:
- Reset (i_rst=1 at a clock edge): all pipeline valids are cleared. o_convolved_data=0, o_convolved_data_valid=0, o_clip=0. User bank is set to identity: coef4=1, all other coefs=0, shift=0. Reset overrides in-flight data; in-flight beats are discarded, not flushed.
- Handshake:
  - stall = o_convolved_data_valid & ~i_out_ready.
  - o_pixel_ready = ~stall (combinational).
  - A beat is accepted when i_pixel_data_valid & o_pixel_ready.
  - While stall is high, every stage, including the output registers, holds its value.
  - No beat is lost or duplicated; output order equals input order.
- Pipeline: 3 registered stages, so an accepted beat appears on the output 3 clock edges later when there is no stall.
  - S1: per-tap product; pixel zero-extended, product signed. i_mode is registered alongside the data.
  - S2: signed 9-term sum into ACC_W.
  - S3: normalise, saturate, register the output.
- Valid bubbles propagate as bubbles; there is no bubble compression.
- Kernels and normalisation (all results are signed before the clamp):
  - box: all coefs 1; result = floor(sum/9), exact for every input (sum is non-negative).
  - gauss: [1 2 1; 2 4 2; 1 2 1]; result = sum >> 4.
  - sharpen: [0 -1 0; -1 5 -1; 0 -1 0]; no shift.
  - user: coefs from the bank; result = arithmetic right shift of sum by the shift value (floor toward negative infinity).
- Saturation: result < 0 gives 0; result > 2^PIXEL_W-1 gives 2^PIXEL_W-1. o_clip=1 whenever a clamp occurred, else 0.
- Coefficient writes:
  - A write takes effect from the next clock edge. A beat accepted in the same cycle as a write uses the old bank; a beat accepted the following cycle uses the new bank.
  - Writes are permitted during streaming and during stall. The bank is captured into S1 products at acceptance, so held beats are unaffected.
  - Writes to addr 10..15 are ignored.
- Mode change between beats is legal and affects only beats accepted afterwards.
- Accumulator never overflows at the default widths: worst case is 9*255*127 or 9*255*(-128).

Test Plan:
- Box, taps k=0..8 equal to k, sustained valid, i_out_ready=1 -> output 4 (36/9), valid exactly 3 cycles after acceptance, o_clip=0; a follow-on all-255 window -> 255.
- Gauss with all taps 255 -> 255, clip=0. Gauss with centre 16, others 0 -> 4.
- Sharpen, centre 200 and neighbours 10 -> 960 clamps to 255, clip=1. Centre 10 and neighbours 200 -> -750 clamps to 0, clip=1.
- User: write coef4=3, others 0, shift=1; centre 101 -> 151. Then write coef0=-3, coef4=0; tap0=1 -> -2 clamps to 0, clip=1. Write to addr 12 -> bank unchanged.
- Backpressure: 6 back-to-back beats (box, values 9,18,...,54 uniform windows); drop i_out_ready for 4 cycles after the first output -> o_pixel_ready low during the stall, output held stable, final sequence 9,18,27,36,45,54 with no loss.
- Reset mid-stream with 2 beats in flight -> next cycle valid=0, data=0, no stale output after release. User mode with centre 77 -> 77, confirming the identity bank.
